cpu_step_ctrl: RTL and testbench

Board-side execution controller that sits directly upstream of the CPU core's clock-enable path. It takes raw pushbutton and slide-switch inputs and synchronises and debounces them. It then produces a one-cycle cpu_en strobe for the core's clock gating, either in free-running mode (slow or fast rate) or in single-step mode (one strobe per button press). It also keeps a wrapping count of issued strobes for the 7-segment status display.

---
 rtl/cpu_step_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// Execution controller: synchronises/debounces board inputs and issues cpu_en strobes
// in RUN (slow/fast rate) or single-step mode. Optional macro STEP_AUTOREPEAT_EN.
module cpu_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SLOW_DIV        = 250000000,
  parameter int unsigned FAST_DIV        = 62500000,
  parameter int unsigned CNT_W           = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_step,
  input  logic       sw_run,
  input  logic       sw_quick,
  output logic       cpu_en,
  output logic [1:0] mode,
  output logic [7:0] step_count,
  output logic       run_active
);

  localparam int unsigned NIN     = 3;
  localparam int unsigned I_STEP  = 0;
  localparam int unsigned I_RUN   = 1;
  localparam int unsigned I_QUICK = 2;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

  typedef enum logic [1:0] {
    PAUSE = 2'b00,
    RUN   = 2'b01,
    HOLD  = 2'b10
  } state_t;

  logic [NIN-1:0]            raw_c;
  logic [NIN-1:0]            sync1_q, sync2_q;
  logic [NIN-1:0]            deb_q, deb_d;
  logic [NIN-1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic                      step_prev_q;
  logic [1:0]                settle_q, settle_d;
  logic                      armed_q, armed_d;
  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          rate_q, rate_d;
  logic                      cpu_en_q, cpu_en_d;
  logic [7:0]                step_count_q, step_count_d;
  logic                      run_active_q;
  logic                      step_rise_c;
  logic                      quick_chg_c;
  logic [CNT_W-1:0]          div_last_c;
`ifdef STEP_AUTOREPEAT_EN
  logic                      rep_q, rep_d;
`endif

  assign raw_c = {sw_quick, sw_run, btn_step};

  // Per-input debounce: value follows the synchroniser only after a full stable window
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < int'(NIN); i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_d[i]     = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // A button held across reset must be seen released before it can step again
  always_comb begin
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd2) & ~sync2_q[I_STEP]);
  end

  assign step_rise_c = deb_q[I_STEP] & ~step_prev_q & armed_q;
  assign quick_chg_c = deb_d[I_QUICK] ^ deb_q[I_QUICK];
  assign div_last_c  = deb_q[I_QUICK] ? FAST_LAST : SLOW_LAST;

  always_comb begin
    state_d  = state_q;
    rate_d   = rate_q;
    cpu_en_d = 1'b0;
`ifdef STEP_AUTOREPEAT_EN
    rep_d    = rep_q & (state_q == HOLD);
`endif
    case (state_q)
      PAUSE: begin
        rate_d = '0;
        if (step_rise_c) begin
          cpu_en_d = 1'b1;
          state_d  = HOLD;
        end else if (deb_q[I_RUN]) begin
          state_d = RUN;
        end
      end
      HOLD: begin
        if (!deb_q[I_STEP]) begin
          state_d = deb_q[I_RUN] ? RUN : PAUSE;
          rate_d  = '0;
        end
`ifdef STEP_AUTOREPEAT_EN
        else if (rate_q == (rep_q ? FAST_LAST : SLOW_LAST)) begin
          cpu_en_d = 1'b1;
          rate_d   = '0;
          rep_d    = 1'b1;
        end else begin
          rate_d = rate_q + CNT_W'(1);
        end
`endif
      end
      RUN: begin
        if (!deb_q[I_RUN]) begin
          state_d = PAUSE;
          rate_d  = '0;
        end else if (quick_chg_c) begin
          rate_d = '0;
        end else if (rate_q == div_last_c) begin
          cpu_en_d = 1'b1;
          rate_d   = '0;
        end else begin
          rate_d = rate_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = PAUSE;
        rate_d  = '0;
      end
    endcase
    step_count_d = step_count_q + 8'(cpu_en_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      deb_cnt_q    <= '0;
      step_prev_q  <= 1'b0;
      settle_q     <= 2'd0;
      armed_q      <= 1'b0;
      state_q      <= PAUSE;
      rate_q       <= '0;
      cpu_en_q     <= 1'b0;
      step_count_q <= 8'd0;
      run_active_q <= 1'b0;
    end else begin
      sync1_q      <= raw_c;
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      deb_cnt_q    <= deb_cnt_d;
      step_prev_q  <= deb_q[I_STEP];
      settle_q     <= settle_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      rate_q       <= rate_d;
      cpu_en_q     <= cpu_en_d;
      step_count_q <= step_count_d;
      run_active_q <= (state_d == RUN);
    end
  end

`ifdef STEP_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_q <= 1'b0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  assign cpu_en     = cpu_en_q;
  assign mode       = state_q;
  assign step_count = step_count_q;
  assign run_active = run_active_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed test-plan steps plus random inputs, all checked
// cycle by cycle against a behavioural model of the controller.
module tb_cpu_step_ctrl;

  localparam int DEB  = 4;
  localparam int SLOW = 10;
  localparam int FAST = 3;
`ifdef STEP_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif
  localparam int MP = 0;
  localparam int MR = 1;
  localparam int MH = 2;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       btn_step = 1'b0;
  logic       sw_run   = 1'b0;
  logic       sw_quick = 1'b0;
  logic       cpu_en;
  logic [1:0] mode;
  logic [7:0] step_count;
  logic       run_active;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Behavioural model state (index 0 step, 1 run, 2 quick)
  bit [2:0] m_s1, m_s2, m_db;
  int       m_dl [3];
  bit       m_dprev, m_armed, m_rep, m_en;
  int       m_edges, m_mode, m_elapsed, m_cnt;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SLOW_DIV       (SLOW),
    .FAST_DIV       (FAST),
    .CNT_W          (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_step  (btn_step),
    .sw_run    (sw_run),
    .sw_quick  (sw_quick),
    .cpu_en    (cpu_en),
    .mode      (mode),
    .step_count(step_count),
    .run_active(run_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0;
    for (int i = 0; i < 3; i++) m_dl[i] = 0;
    m_dprev = 0; m_armed = 0; m_rep = 0; m_en = 0;
    m_edges = 0; m_mode = MP; m_elapsed = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit [2:0] raw, ndb;
    int       nl [3];
    bit       rise, qchg, en;
    int       div;
    raw  = {sw_quick, sw_run, btn_step};
    rise = m_db[0] && !m_dprev && m_armed;
    div  = m_db[2] ? FAST : SLOW;
    ndb  = m_db;
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] == m_db[i]) nl[i] = 0;
      else if (m_dl[i] + 1 == DEB) begin ndb[i] = m_s2[i]; nl[i] = 0; end
      else nl[i] = m_dl[i] + 1;
    end
    qchg = (ndb[2] != m_db[2]);
    en   = 1'b0;
    if (m_mode == MP) begin
      m_elapsed = 0;
      m_rep     = 0;
      if (rise) begin en = 1'b1; m_mode = MH; end
      else if (m_db[1]) m_mode = MR;
    end else if (m_mode == MH) begin
      if (!m_db[0]) begin
        m_mode = m_db[1] ? MR : MP;
        m_elapsed = 0;
        m_rep = 0;
      end else if (AUTOREP) begin
        m_elapsed++;
        if (m_elapsed == (m_rep ? FAST : SLOW)) begin en = 1'b1; m_elapsed = 0; m_rep = 1; end
      end
    end else begin
      if (!m_db[1]) begin m_mode = MP; m_elapsed = 0; end
      else if (qchg) m_elapsed = 0;
      else begin
        m_elapsed++;
        if (m_elapsed == div) begin en = 1'b1; m_elapsed = 0; end
      end
    end
    if (m_edges >= 2 && !m_s2[0]) m_armed = 1'b1;
    if (m_edges < 2) m_edges++;
    m_dprev = m_db[0];
    m_db    = ndb;
    for (int i = 0; i < 3; i++) m_dl[i] = nl[i];
    m_s2 = m_s1;
    m_s1 = raw;
    m_en = en;
    if (en) m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    @(negedge clk);
    check("cycle", {20'd0, cpu_en, mode, step_count, run_active},
          {20'd0, m_en, 2'(m_mode), 8'(m_cnt), (m_mode == MR)});
  endtask

  task automatic run_cycles(input int n, output int strobes, output int first);
    strobes = 0;
    first   = -1;
    for (int k = 1; k <= n; k++) begin
      cycle();
      if (cpu_en === 1'b1) begin
        strobes++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic wait_mode(input logic [1:0] target, input int budget, input string tag);
    int k;
    k = 0;
    while (mode !== target && k < budget) begin
      cycle();
      k++;
    end
    check(tag, 32'(mode), 32'(target));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic press(input int hold, input int rel);
    int n, f;
    btn_step = 1'b1;
    run_cycles(hold, n, f);
    btn_step = 1'b0;
    run_cycles(rel, n, f);
  endtask

  initial begin
    int n, f;
    int left [3];
    bit [2:0] val;

    // Reset state
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_mode", 32'(mode), 0);
    check("rst_step_count", 32'(step_count), 0);
    check("rst_run_active", 32'(run_active), 0);
    reset = 1'b0;
    repeat (3) cycle();

    // 1: single press held 20 cycles
    btn_step = 1'b1;
    run_cycles(20, n, f);
    check("t1_first_strobe", f, 7);
    check("t1_strobes", n, AUTOREP ? 3 : 1);
    btn_step = 1'b0;
    run_cycles(6, n, f);
    check("t1_still_hold", 32'(mode), 2);
    cycle();
    check("t1_back_pause", 32'(mode), 0);
    check("t1_step_count", 32'(step_count), AUTOREP ? 5 : 1);

    // 2: bouncing button never steps
    do_reset();
    btn_step = 1'b1; cycle();
    btn_step = 1'b0; cycle();
    btn_step = 1'b1; cycle();
    btn_step = 1'b0;
    run_cycles(15, n, f);
    check("t2_strobes", n, 0);
    check("t2_step_count", 32'(step_count), 0);
    check("t2_mode", 32'(mode), 0);

    // 3: free run slow, then switch to fast
    do_reset();
    sw_run = 1'b1;
    wait_mode(2'b01, 20, "t3_enter_run");
    run_cycles(50, n, f);
    check("t3_slow_strobes", n, 5);
    check("t3_first_slow", f, 10);
    check("t3_run_active", 32'(run_active), 1);
    sw_quick = 1'b1;
    run_cycles(12, n, f);
    check("t3_first_fast", f, 9);
    check("t3_fast_strobes", n, 2);

    // 4: run dropped exactly on terminal count
    sw_run = 1'b0; sw_quick = 1'b0;
    do_reset();
    sw_run = 1'b1;
    wait_mode(2'b01, 20, "t4_enter_run");
    run_cycles(13, n, f);
    check("t4_pre_strobe", f, 10);
    sw_run = 1'b0;
    run_cycles(7, n, f);
    check("t4_no_strobe", n, 0);
    check("t4_mode_pause", 32'(mode), 0);
    sw_run = 1'b1;
    run_cycles(25, n, f);
    check("t4_rerun_first", f, 17);

    // 5: reset during HOLD with button still held
    sw_run = 1'b0;
    do_reset();
    repeat (4) press(8, 10);
    btn_step = 1'b1;
    run_cycles(10, n, f);
    check("t5_hold_mode", 32'(mode), 2);
    check("t5_hold_count", 32'(step_count), 5);
    reset = 1'b1;
    model_reset();
    #1;
    check("t5_rst_cpu_en", 32'(cpu_en), 0);
    check("t5_rst_mode", 32'(mode), 0);
    check("t5_rst_count", 32'(step_count), 0);
    check("t5_rst_run_active", 32'(run_active), 0);
    @(negedge clk);
    reset = 1'b0;
    run_cycles(30, n, f);
    check("t5_held_no_strobe", n, 0);
    btn_step = 1'b0;
    run_cycles(10, n, f);
    btn_step = 1'b1;
    run_cycles(10, n, f);
    check("t5_new_press", n, 1);
    btn_step = 1'b0;
    run_cycles(10, n, f);

    // 6: step_count wrap and held-button behaviour
    do_reset();
    repeat (255) press(8, 8);
    check("t6_count_255", 32'(step_count), 255);
    press(8, 8);
    check("t6_count_wrap", 32'(step_count), 0);
    btn_step = 1'b1;
    wait_mode(2'b10, 15, "t6_enter_hold");
    run_cycles(30, n, f);
    check("t6_repeat_first", f, AUTOREP ? 10 : -1);
    check("t6_repeat_strobes", n, AUTOREP ? 7 : 0);
    btn_step = 1'b0;
    run_cycles(10, n, f);

    // Random inputs with glitches, long holds and occasional resets
    for (int i = 0; i < 3; i++) left[i] = 0;
    val = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (left[i] == 0) begin
          val[i]  = 1'($urandom_range(0, 1));
          left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(4, 30));
        end
        left[i]--;
      end
      btn_step = val[0];
      sw_run   = val[1];
      sw_quick = val[2];
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        model_reset();
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
